axi_bresp_gen: RTL and testbench

AXI write-response channel driver for the slave side of an AXI port. It queues write-completion records from the slave's write datapath and presents them on B with AXI handshake rules: BVALID low after reset, BVALID/BRESP/BID held stable until BREADY, and no X on outputs. It also watches for master back-pressure beyond a bound and raises a sticky stall flag, which is the design-side counterpart of the B-channel protocol checker.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_sync_fifo.sv | 50 +++++
 rtl/axi_bresp_gen.sv | 82 ++++++++
 tb/tb_axi_bresp_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI response encodings and the B-channel entry record
package axi_pkg;

  localparam int AXI_ID_WIDTH = 4;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef struct packed {
    resp_t                   resp;
    logic [AXI_ID_WIDTH-1:0] id;
  } b_entry_t;

  // SLVERR and DECERR both have the upper response bit set
  function automatic logic is_err(resp_t r);
    return r[1];
  endfunction

endpackage

// File: rtl/axi_sync_fifo.sv
// axi_sync_fifo: circular synchronous FIFO with registered storage
module axi_sync_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  T                         wr_data,
  output T                         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  T              mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // pointers wrap naturally; count only moves when exactly one side fires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push != do_pop) count <= do_push ? count + (AW+1)'(1) : count - (AW+1)'(1);
    end
  end

  // payload storage needs no reset; readers gate it with empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/axi_bresp_gen.sv
// axi_bresp_gen: queues write completions and drives the AXI B channel
module axi_bresp_gen
  import axi_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ID_WIDTH = 4,
  parameter int MAXWAIT  = 5
) (
  input  logic                AXI_ACLK,
  input  logic                AXI_ARESETN,
  input  logic                wr_done_valid,
  output logic                wr_done_ready,
  input  logic [1:0]          wr_done_resp,
  input  logic [ID_WIDTH-1:0] wr_done_id,
  output logic                AXI_BVALID,
  input  logic                AXI_BREADY,
  output logic [1:0]          AXI_BRESP,
  output logic [ID_WIDTH-1:0] AXI_BID,
  output logic                stall_err,
  output logic                err_resp_seen
);

  localparam int            WW       = $clog2(MAXWAIT+1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAXWAIT);

  typedef struct packed {
    resp_t               resp;
    logic [ID_WIDTH-1:0] id;
  } entry_t;

  entry_t                 wr_entry;
  entry_t                 rd_entry;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   waiting;
  logic [$clog2(DEPTH):0] count;
  logic [WW-1:0]          wait_cnt;

  assign wr_entry      = '{resp: resp_t'(wr_done_resp), id: wr_done_id};
  assign wr_done_ready = AXI_ARESETN && !full;
  assign push          = wr_done_valid && wr_done_ready;
  assign pop           = AXI_BVALID && AXI_BREADY;
  assign waiting       = AXI_BVALID && !AXI_BREADY;
  assign AXI_BVALID    = count != '0;
  assign AXI_BRESP     = empty ? 2'b00 : rd_entry.resp;
  assign AXI_BID       = empty ? '0 : rd_entry.id;

  axi_sync_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk     (AXI_ACLK),
    .rst_n   (AXI_ARESETN),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .rd_data (rd_entry),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // count consecutive back-pressure cycles and latch a stall once the bound is exceeded
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      wait_cnt  <= '0;
      stall_err <= 1'b0;
    end else begin
      wait_cnt  <= !waiting ? '0 : (wait_cnt == WAIT_MAX ? wait_cnt : wait_cnt + WW'(1));
      stall_err <= stall_err || (waiting && wait_cnt == WAIT_MAX);
    end
  end

  // latch that an error response actually left on the bus
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) err_resp_seen <= 1'b0;
    else err_resp_seen <= err_resp_seen || (pop && is_err(rd_entry.resp));
  end

endmodule

// File: tb/tb_axi_bresp_gen.sv
// tb_axi_bresp_gen: scoreboard bench for the B-channel response generator
module tb_axi_bresp_gen;

  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wv = 1'b0;
  logic           wrdy;
  logic [1:0]     wresp = 2'b00;
  logic [IDW-1:0] wid = '0;
  logic           bv;
  logic           br = 1'b0;
  logic [1:0]     bresp;
  logic [IDW-1:0] bid;
  logic           stall;
  logic           errs;

  logic [IDW+1:0] exp_q[$];
  logic [IDW+1:0] got_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_bresp_gen #(.DEPTH(4), .ID_WIDTH(IDW), .MAXWAIT(5)) dut (
    .AXI_ACLK      (clk),
    .AXI_ARESETN   (rst_n),
    .wr_done_valid (wv),
    .wr_done_ready (wrdy),
    .wr_done_resp  (wresp),
    .wr_done_id    (wid),
    .AXI_BVALID    (bv),
    .AXI_BREADY    (br),
    .AXI_BRESP     (bresp),
    .AXI_BID       (bid),
    .stall_err     (stall),
    .err_resp_seen (errs)
  );

  // record the handshakes the coming rising edge will perform, then move to the next falling edge
  task automatic step();
    if (wv && wrdy) exp_q.push_back({wresp, wid});
    if (bv && br) got_q.push_back({bresp, bid});
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bv !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", bv); end
    checks++; if (wrdy !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", wrdy); end
    checks++; if ({bresp, bid} !== '0) begin errors++; $display("FAIL rst_bresp_bid: got %h want 0", {bresp, bid}); end
    checks++; if ({stall, errs} !== 2'b00) begin errors++; $display("FAIL rst_flags: got %b want 00", {stall, errs}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (wrdy !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", wrdy); end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (bv !== 1'b0) begin errors++; $display("FAIL idle_bvalid: cycle %0d got %b want 0", i, bv); end
      step();
    end
  endtask

  task automatic test_single();
    logic [IDW+1:0] g, e;
    br = 1'b0; wv = 1'b1; wid = 4'd3; wresp = 2'b00;
    step();
    wv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bv, bresp, bid} !== {1'b1, 2'b00, 4'd3}) begin errors++; $display("FAIL single_hold: wait %0d got v=%b r=%b id=%0d want v=1 r=00 id=3", i, bv, bresp, bid); end
      step();
    end
    br = 1'b1;
    step();
    br = 1'b0;
    checks++; if (bv !== 1'b0) begin errors++; $display("FAIL single_drop: got %b want 0", bv); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL single_stall: got %b want 0", stall); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL single_sb: got %h want %h", g, e); end
    end
  endtask

  task automatic test_fill();
    logic [IDW+1:0] g, e;
    br = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wv = 1'b1; wid = IDW'(i); wresp = 2'b00;
      checks++; if (wrdy !== 1'b1) begin errors++; $display("FAIL fill_ready: push %0d got %b want 1", i, wrdy); end
      step();
    end
    wv = 1'b0;
    checks++; if (wrdy !== 1'b0) begin errors++; $display("FAIL fill_full: got %b want 0", wrdy); end
    br = 1'b1;
    step();
    checks++; if (wrdy !== 1'b1) begin errors++; $display("FAIL fill_reopen: got %b want 1", wrdy); end
    for (int i = 0; i < 3; i++) step();
    br = 1'b0;
    checks++; if (bv !== 1'b0) begin errors++; $display("FAIL fill_empty: got %b want 0", bv); end
    checks++; if (got_q.size() !== 4) begin errors++; $display("FAIL fill_count: got %0d want 4", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL fill_order: got %h want %h", g, e); end
    end
  endtask

  task automatic test_full_simul();
    logic [IDW+1:0] g, e;
    br = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wv = 1'b1; wid = IDW'(i); wresp = 2'b01;
      step();
    end
    wid = 4'd7; br = 1'b1;
    checks++; if (wrdy !== 1'b0) begin errors++; $display("FAIL simul_full: got %b want 0", wrdy); end
    step();
    checks++; if (wrdy !== 1'b1) begin errors++; $display("FAIL simul_space: got %b want 1", wrdy); end
    step();
    wv = 1'b0;
    checks++; if ({wrdy, bv, bid} !== {1'b1, 1'b1, 4'd3}) begin errors++; $display("FAIL simul_hold: got rdy=%b v=%b id=%0d want rdy=1 v=1 id=3", wrdy, bv, bid); end
    for (int i = 0; i < 3; i++) step();
    br = 1'b0;
    checks++; if (bv !== 1'b0) begin errors++; $display("FAIL simul_empty: got %b want 0", bv); end
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL simul_count: got %0d want 5", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL simul_order: got %h want %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [IDW+1:0] g, e;
    br = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wv = 1'b1; wid = IDW'(8 + i); wresp = 2'(i % 2);
      step();
      checks++; if ({bv, bid} !== {1'b1, 4'(8 + i)}) begin errors++; $display("FAIL b2b_stream: beat %0d got v=%b id=%0d want v=1 id=%0d", i, bv, bid, 8 + i); end
    end
    wv = 1'b0;
    step();
    br = 1'b0;
    checks++; if (bv !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", bv); end
    checks++; if (got_q.size() !== 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", got_q.size()); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_order: got %h want %h", g, e); end
    end
  endtask

  task automatic test_stall_err();
    logic [IDW+1:0] g, e;
    br = 1'b0; wv = 1'b1; wid = 4'd5; wresp = 2'b00;
    step();
    wv = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_early: wait %0d got %b want 0", i, stall); end
      step();
    end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_set: got %b want 1", stall); end
    br = 1'b1;
    step();
    checks++; if ({stall, bv} !== 2'b10) begin errors++; $display("FAIL stall_sticky: got stall=%b v=%b want stall=1 v=0", stall, bv); end
    checks++; if (errs !== 1'b0) begin errors++; $display("FAIL err_early: got %b want 0", errs); end
    wv = 1'b1; wid = 4'd9; wresp = 2'b11;
    step();
    wv = 1'b0;
    checks++; if ({bv, bresp, errs} !== {1'b1, 2'b11, 1'b0}) begin errors++; $display("FAIL err_pending: got v=%b r=%b err=%b want v=1 r=11 err=0", bv, bresp, errs); end
    step();
    br = 1'b0;
    checks++; if (errs !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", errs); end
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
      checks++; if (g !== e) begin errors++; $display("FAIL stall_sb: got %h want %h", g, e); end
    end
  endtask

  task automatic test_reset_mid();
    br = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wv = 1'b1; wid = IDW'(10 + i); wresp = 2'b10;
      step();
    end
    wv = 1'b0;
    checks++; if (bv !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", bv); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bv, wrdy, bresp, bid} !== '0) begin errors++; $display("FAIL mid_async: got v=%b rdy=%b r=%b id=%0d want all 0", bv, wrdy, bresp, bid); end
    checks++; if ({stall, errs} !== 2'b00) begin errors++; $display("FAIL mid_flags: got %b want 00", {stall, errs}); end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    br = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bv, bid} !== '0) begin errors++; $display("FAIL mid_stale: cycle %0d got v=%b id=%0d want v=0 id=0", i, bv, bid); end
      step();
    end
    br = 1'b0;
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL mid_nopop: got %0d want 0", got_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_back_to_back();
    test_stall_err();
    test_reset_mid();
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
